// File: rtl/key_event_if.sv
// key_event_if: debounced key level in, gesture event pulses and debug state out.
interface key_event_if;
    logic       keyDeBounce;
    logic       pressPulse;
    logic       releasePulse;
    logic       clickPulse;
    logic       dblClickPulse;
    logic       longPulse;
    logic       repeatPulse;
    logic       keyHeld;
    logic [2:0] fsmState;
    modport master (
        output keyDeBounce,
        input  pressPulse, releasePulse, clickPulse, dblClickPulse,
               longPulse, repeatPulse, keyHeld, fsmState
    );
    modport slave (
        input  keyDeBounce,
        output pressPulse, releasePulse, clickPulse, dblClickPulse,
               longPulse, repeatPulse, keyHeld, fsmState
    );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns a debounced active-low key into press/release/click/double-click/long/repeat pulses.
module key_event_decoder #(
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int DCLICK_TICKS = 300,
    parameter int CNT_W        = 16
) (
    input logic        clk,
    input logic        rst,
    key_event_if.slave kif
);
    typedef enum logic [2:0] {IDLE = 3'd0, PRESS = 3'd1, HOLD = 3'd2, GAP = 3'd3, PRESS2 = 3'd4} state_t;
    localparam logic [CNT_W-1:0] LONG_END   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_END = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] DCLICK_END = CNT_W'(DCLICK_TICKS - 1);
    state_t           state, nextState;
    logic [CNT_W-1:0] cnt;
    logic             prevKey, fall, rise, clr;
    logic             pressN, releaseN, clickN, dblN, longN, repeatN;
    assign fall = prevKey & ~kif.keyDeBounce;
    assign rise = ~prevKey & kif.keyDeBounce;
    // Edges are tested before counter terminals so an edge always wins a tie.
    always_comb begin
        nextState = state;
        pressN    = 1'b0;
        releaseN  = 1'b0;
        clickN    = 1'b0;
        dblN      = 1'b0;
        longN     = 1'b0;
        repeatN   = 1'b0;
        case (state)
            IDLE: if (fall) begin
                nextState = PRESS;
                pressN    = 1'b1;
            end
            PRESS: if (rise) begin
                nextState = GAP;
                releaseN  = 1'b1;
            end else if (cnt == LONG_END) begin
                nextState = HOLD;
                longN     = 1'b1;
            end
            HOLD: if (rise) begin
                nextState = IDLE;
                releaseN  = 1'b1;
            end else if (cnt == REPEAT_END) begin
                repeatN   = 1'b1;
            end
            GAP: if (fall) begin
                nextState = PRESS2;
                pressN    = 1'b1;
            end else if (cnt == DCLICK_END) begin
                nextState = IDLE;
                clickN    = 1'b1;
            end
            PRESS2: if (rise) begin
                nextState = IDLE;
                releaseN  = 1'b1;
                dblN      = 1'b1;
            end else if (cnt == LONG_END) begin
                nextState = HOLD;
                longN     = 1'b1;
            end
            default: nextState = IDLE;
        endcase
        clr = (nextState != state) | repeatN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            prevKey           <= 1'b1;
            kif.pressPulse    <= 1'b0;
            kif.releasePulse  <= 1'b0;
            kif.clickPulse    <= 1'b0;
            kif.dblClickPulse <= 1'b0;
            kif.longPulse     <= 1'b0;
            kif.repeatPulse   <= 1'b0;
            kif.keyHeld       <= 1'b0;
            kif.fsmState      <= 3'd0;
        end else begin
            state             <= nextState;
            cnt               <= clr ? '0 : cnt + 1'b1;
            prevKey           <= kif.keyDeBounce;
            kif.pressPulse    <= pressN;
            kif.releasePulse  <= releaseN;
            kif.clickPulse    <= clickN;
            kif.dblClickPulse <= dblN;
            kif.longPulse     <= longN;
            kif.repeatPulse   <= repeatN;
            kif.keyHeld       <= (nextState == PRESS) | (nextState == PRESS2) | (nextState == HOLD);
            kif.fsmState      <= nextState;
        end
    end
endmodule
